// File: rtl/instr_word_encoder.sv
// Encodes ALU/jump field sets into 16-bit instruction words and streams them
// through a small FIFO to an auto-incrementing instruction-memory write port.
module instr_word_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [AW-1:0]            base,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [1:0]               rn,
    input  logic [1:0]               rm,
    input  logic [1:0]               rx,
    input  logic [1:0]               cmode,
    input  logic [1:0]               smode,
    input  logic [3:0]               amt,
    input  logic [8:0]               imm,
    output logic                     mem_we,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [15:0]              mem_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic                     done
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     count_reg, count_next;
    logic            err_reg, err_next;
    logic            done_reg, done_next;
    logic [15:0]     fifo_mem [DEPTH];

    logic [15:0]     word_enc;
    logic            op_legal;
    logic            accept, push, pop;

    // Field packing follows the decoder layout; unused inputs never reach the word.
    always_comb begin
        word_enc = '0;
        op_legal = 1'b1;
        case (op)
            4'd0: word_enc = {5'b00001, 1'b0, cmode, smode, rx, rn, rm};
            4'd1: word_enc = {5'b00101, 1'b0, cmode, smode, rx, rn, rm};
            4'd2: word_enc = {5'b01001, 1'b0, cmode, smode, rx, rn, rm};
            4'd3: word_enc = {5'b01100, 1'b0, cmode, smode, rx, rn, rm};
            4'd4: word_enc = {5'b00100, rn, imm};
            4'd5: word_enc = {5'b01000, rn, imm};
            4'd6: word_enc = {5'b01010, 1'b0, cmode, amt, 2'b00, rm};
            4'd7: word_enc = {5'b01011, 1'b0, cmode, amt, 2'b00, rm};
            4'd8: word_enc = {5'b11100, 1'b0, cmode, smode, rx, rn, rm};
            default: op_legal = 1'b0;
        endcase
    end

    assign in_ready = (state_reg == RUN) && (count_reg < FULL_COUNT);
    assign mem_we   = (state_reg != IDLE) && (count_reg != '0);
    assign accept   = in_valid && in_ready;
    assign push     = accept && op_legal;
    assign pop      = mem_we && mem_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (start)     state_next = RUN;
                else if (stop) state_next = DRAIN;
            end
            DRAIN: begin
                if (start) begin
                    state_next = RUN;
                end else if (count_next == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A fresh START both reloads the address and clears any earlier illegal-op flag.
    always_comb begin
        addr_next = addr_reg;
        if (start)    addr_next = base;
        else if (pop) addr_next = addr_reg + 1'b1;
        err_next = (err_reg && !start) || (accept && !op_legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= word_enc;
    end

    // Head is gated so stale storage never shows when no write is offered.
    assign mem_data = mem_we ? fifo_mem[rd_ptr_reg] : 16'h0000;
    assign mem_addr = addr_reg;
    assign count    = count_reg;
    assign err      = err_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed vector bench for instr_word_encoder: field-set table plus hand-built
// stall, illegal-op, wrap/drain and mid-operation reset sequences.
module tb_instr_word_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rn;
        logic [1:0]  rm;
        logic [1:0]  rx;
        logic [1:0]  cmode;
        logic [1:0]  smode;
        logic [3:0]  amt;
        logic [8:0]  imm;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] base = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [1:0]    rn = '0, rm = '0, rx = '0, cmode = '0, smode = '0;
    logic [3:0]    amt = '0;
    logic [8:0]    imm = '0;
    logic          mem_we;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic [2:0]    count;
    logic          err;
    logic          done;

    instr_word_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base(base),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rn(rn), .rm(rm),
        .rx(rx), .cmode(cmode), .smode(smode), .amt(amt), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .count(count), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    logic [AW+15:0] exp_q [$];
    int wcyc [$];
    vec_t vt [10];
    vec_t bad;

    always @(posedge clk) cyc <= cyc + 1;

    // Write scoreboard: every accepted memory write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            logic [AW+15:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_data, e[AW+15:16], e[15:0]);
                end else begin
                    $display("write addr=%h data=%h ok", mem_addr, mem_data);
                end
            end
            last_wr_cyc = cyc;
            wcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_mem_we"},   32'(mem_we),   0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_data"}, 32'(mem_data), 0);
        chk({tag, "_count"},    32'(count),    0);
        chk({tag, "_err"},      32'(err),      0);
        chk({tag, "_done"},     32'(done),     0);
    endtask

    task automatic push(input vec_t v, input logic expect_write, input logic [AW-1:0] a);
        int n = 0;
        if (expect_write) exp_q.push_back({a, v.exp});
        op = v.op; rn = v.rn; rm = v.rm; rx = v.rx;
        cmode = v.cmode; smode = v.smode; amt = v.amt; imm = v.imm;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse(input logic do_start, input logic do_stop, input logic [AW-1:0] b);
        start = do_start; stop = do_stop; base = b;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] a;
        vt[0] = '{4'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 4'hF, 9'h155, 16'h0939};
        vt[1] = '{4'd4, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 4'h7, 9'h1A5, 16'h27A5};
        vt[2] = '{4'd7, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3, 4'h5, 9'h1FF, 16'h5A52};
        vt[3] = '{4'd8, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'hF, 9'h0AA, 16'hE004};
        vt[4] = '{4'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 4'h0, 9'h000, 16'h2A4E};
        vt[5] = '{4'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd3, 4'h0, 9'h000, 16'h4BD3};
        vt[6] = '{4'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 4'h0, 9'h000, 16'h60A5};
        vt[7] = '{4'd5, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 4'h3, 9'h0FF, 16'h40FF};
        vt[8] = '{4'd6, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 4'hA, 9'h000, 16'h51A3};
        vt[9] = '{4'd4, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0, 9'h000, 16'h2200};
        bad   = '{4'd12, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 4'h1, 9'h001, 16'h0000};

        // Power-on reset
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: encodings streamed back-to-back with memory always ready
        mem_ready = 1'b1;
        pulse(1'b1, 1'b0, 8'h10);
        chk("start_addr", 32'(mem_addr), 32'h10);
        chk("run_in_ready", 32'(in_ready), 1);
        a = 8'h10;
        wcyc.delete();
        for (int i = 0; i < 10; i++) begin
            push(vt[i], 1'b1, a);
            a = a + 1'b1;
        end
        wait_drain("table_drain");
        if (wcyc.size() == 10) chk("table_throughput", 32'(wcyc[9] - wcyc[0]), 9);

        // Stall: fill the FIFO, fifth word waits until memory releases
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(vt[i], 1'b1, a + 8'(i));
        end
        fork
            push(vt[4], 1'b1, a + 8'd4);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 0);
                    chk("stall_mem_we",   32'(mem_we),   1);
                    chk("stall_count",    32'(count),    4);
                    chk("stall_data",     32'(mem_data), 32'h0939);
                    chk("stall_addr",     32'(mem_addr), 32'(a));
                end
                @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");

        // Illegal opcode is handshaken, dropped, and flags err until next START
        pulse(1'b1, 1'b0, 8'h40);
        push(vt[0], 1'b1, 8'h40);
        chk("err_before_illegal", 32'(err), 0);
        push(bad, 1'b0, 8'h00);
        chk("err_after_illegal", 32'(err), 1);
        push(vt[1], 1'b1, 8'h41);
        wait_drain("illegal_drain");
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 1);
        @(posedge clk);
        #1;

        // START with STOP in the same cycle: START wins, address reloads, err clears
        pulse(1'b1, 1'b1, 8'hFF);
        chk("startstop_run", 32'(in_ready), 1);
        chk("startstop_err", 32'(err), 0);
        chk("startstop_addr", 32'(mem_addr), 32'hFF);

        // Address wrap and drain: DONE once, the cycle after the final pop
        mem_ready = 1'b0;
        done_cnt = 0;
        push(vt[2], 1'b1, 8'hFF);
        push(vt[3], 1'b1, 8'h00);
        pulse(1'b0, 1'b1, 8'h00);
        chk("drain_in_ready", 32'(in_ready), 0);
        mem_ready = 1'b1;
        wait_drain("wrap_drain");
        repeat (4) @(negedge clk);
        chk("done_once", 32'(done_cnt), 1);
        chk("done_timing", 32'(done_cyc - last_wr_cyc), 1);
        chk("idle_mem_we", 32'(mem_we), 0);
        chk("idle_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;

        // Reset with words queued: outputs clear at once and nothing is written
        pulse(1'b1, 1'b0, 8'h80);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(vt[5 + i], 1'b0, 8'h00);
        end
        chk("pre_reset_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_mem_we", 32'(mem_we), 0);
        chk("post_reset_count", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
